issue_ctrl: RTL and testbench

Issue-stage sequencer between decode and the execute units of the RV64 core. It keeps a 32-entry register scoreboard of in-flight destination writes. It stalls decode on RAW/WAW hazards, on outstanding-limit exhaustion and on execute back-pressure. It serialises system instructions (csr/ecall/ebreak/mret) by draining all in-flight writers and then holding issue until the system-control unit reports completion.

---
 rtl/core_pkg.sv | 12 +
 rtl/issue_ctrl_scoreboard.sv | 66 ++++++
 rtl/issue_ctrl.sv | 101 ++++++++++
 tb/tb_issue_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared issue-stage types and constants
package core_pkg;

  localparam int NUM_XREG = 32;

  typedef enum logic [1:0] {
    ISS_RUN    = 2'd0,
    ISS_DRAIN  = 2'd1,
    ISS_SERIAL = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// rtl/issue_ctrl_scoreboard.sv - register busy mask and in-flight writer counter
module issue_ctrl_scoreboard
  import core_pkg::*;
#(
  parameter int MAX_OUT   = 4,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_vld,
  input  logic [4:0]          set_rd,
  input  logic                wb_vld,
  input  logic [4:0]          wb_rd,
  output logic                clr,
  output logic                at_limit,
  output logic [NUM_XREG-1:0] busy_mask,
  output logic [NUM_XREG-1:0] eff_busy,
  output logic [3:0]          outstanding
);

  logic [NUM_XREG-1:0] busy_q, busy_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                inc;

  // A writeback only retires something if its bit is actually set; stale ones are dropped.
  always_comb begin
    clr      = wb_vld & (wb_rd != 5'd0) & busy_q[wb_rd];
    inc      = set_vld & (set_rd != 5'd0);
    at_limit = (cnt_q == 4'(MAX_OUT));
    eff_busy = busy_q;
    if (BYPASS_WB && clr) eff_busy[wb_rd] = 1'b0;
  end

  // Next mask: clear first so a new writer to the retiring register keeps its bit.
  always_comb begin
    busy_d = busy_q;
    if (clr) busy_d[wb_rd] = 1'b0;
    if (inc) busy_d[set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Counter moves only on a lone increment or lone decrement, with saturation guards.
  always_comb begin
    cnt_d = cnt_q;
    case ({inc, clr})
      2'b10:   if (cnt_q < 4'(MAX_OUT)) cnt_d = cnt_q + 4'd1;
      2'b01:   if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_mask   = busy_q;
  assign outstanding = cnt_q;

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - issue sequencer with hazard stall and system-op serialisation
module issue_ctrl
  import core_pkg::*;
#(
  parameter int MAX_OUT   = 4,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_inst_vld,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_vld,
  input  logic        dec_rs2_vld,
  input  logic        dec_dst_vld,
  input  logic        dec_serial,
  output logic        dec_ready,
  output logic        issue_vld,
  input  logic        issue_ready,
  input  logic        wb_vld,
  input  logic [4:0]  wb_rd,
  input  logic        sys_done,
  input  logic        flush,
  output logic [31:0] busy_mask,
  output logic [3:0]  outstanding,
  output logic [1:0]  state_o
);

  issue_state_e        state_q, state_d;
  logic [NUM_XREG-1:0] eff_busy;
  logic                clr, at_limit;
  logic                wr, hazard, state_ok, can_issue, issue_fire, drained;

  issue_ctrl_scoreboard #(
    .MAX_OUT  (MAX_OUT),
    .BYPASS_WB(BYPASS_WB)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_vld    (issue_fire & wr),
    .set_rd     (dec_rd),
    .wb_vld     (wb_vld),
    .wb_rd      (wb_rd),
    .clr        (clr),
    .at_limit   (at_limit),
    .busy_mask  (busy_mask),
    .eff_busy   (eff_busy),
    .outstanding(outstanding)
  );

  // Hazard detection and issue gating; the limit stall lifts when a writer retires this cycle.
  always_comb begin
    wr      = dec_dst_vld & (dec_rd != 5'd0);
    drained = (outstanding == 4'd0);
    hazard  = (dec_rs1_vld & eff_busy[dec_rs1]) |
              (dec_rs2_vld & eff_busy[dec_rs2]) |
              (wr & eff_busy[dec_rd]) |
              (wr & at_limit & ~clr);
    case (state_q)
      ISS_RUN:   state_ok = ~dec_serial | drained;
      ISS_DRAIN: state_ok = dec_serial & drained;
      default:   state_ok = 1'b0;
    endcase
    can_issue  = ~rst & dec_inst_vld & ~hazard & ~flush & state_ok;
    issue_fire = can_issue & issue_ready;
    issue_vld  = can_issue;
    dec_ready  = ~rst & issue_ready & (can_issue | ~dec_inst_vld);
  end

  // Serialisation FSM next state; flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ISS_RUN;
    end else begin
      case (state_q)
        ISS_RUN: begin
          if (issue_fire && dec_serial) state_d = ISS_SERIAL;
          else if (dec_inst_vld && dec_serial && !drained) state_d = ISS_DRAIN;
        end
        ISS_DRAIN: begin
          if (issue_fire && dec_serial) state_d = ISS_SERIAL;
        end
        ISS_SERIAL: begin
          if (sys_done) state_d = ISS_RUN;
        end
        default: state_d = ISS_RUN;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ISS_RUN;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - scoreboard-driven directed bench for issue_ctrl
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_inst_vld, dec_rs1_vld, dec_rs2_vld, dec_dst_vld, dec_serial;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_ready, issue_vld, issue_ready;
  logic        wb_vld, sys_done, flush;
  logic [4:0]  wb_rd;
  logic [31:0] busy_mask;
  logic [3:0]  outstanding;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  bit [31:0] exp_iv_q[$];
  bit [31:0] exp_dr_q[$];
  string     tag_q[$];

  issue_ctrl #(.MAX_OUT(4), .BYPASS_WB(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_inst_vld(dec_inst_vld),
    .dec_rd      (dec_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rs1_vld (dec_rs1_vld),
    .dec_rs2_vld (dec_rs2_vld),
    .dec_dst_vld (dec_dst_vld),
    .dec_serial  (dec_serial),
    .dec_ready   (dec_ready),
    .issue_vld   (issue_vld),
    .issue_ready (issue_ready),
    .wb_vld      (wb_vld),
    .wb_rd       (wb_rd),
    .sys_done    (sys_done),
    .flush       (flush),
    .busy_mask   (busy_mask),
    .outstanding (outstanding),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input bit [31:0] obs, input bit [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input int vld, input int rd, input int rs1, input int r1v,
                         input int rs2, input int r2v, input int dv, input int ser);
    dec_inst_vld = 1'(vld);
    dec_rd       = 5'(rd);
    dec_rs1      = 5'(rs1);
    dec_rs1_vld  = 1'(r1v);
    dec_rs2      = 5'(rs2);
    dec_rs2_vld  = 1'(r2v);
    dec_dst_vld  = 1'(dv);
    dec_serial   = 1'(ser);
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_inst(input int rd);
    set_dec(1, rd, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic ecall();
    set_dec(1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wb(input int rd);
    wb_vld = 1'b1;
    wb_rd  = 5'(rd);
  endtask

  // Push the expected handshake for the driven stimulus, then pop it when sampling the DUT.
  task automatic tick(input string tag, input bit [31:0] exp_iv, input bit [31:0] exp_dr);
    bit [31:0] e_iv, e_dr;
    string     t;
    exp_iv_q.push_back(exp_iv);
    exp_dr_q.push_back(exp_dr);
    tag_q.push_back(tag);
    #3;
    e_iv = exp_iv_q.pop_front();
    e_dr = exp_dr_q.pop_front();
    t    = tag_q.pop_front();
    check({t, ".issue_vld"}, 32'(issue_vld), e_iv);
    check({t, ".dec_ready"}, 32'(dec_ready), e_dr);
    @(posedge clk);
    #1;
    wb_vld   = 1'b0;
    wb_rd    = 5'd0;
    flush    = 1'b0;
    sys_done = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input bit [31:0] busy, input bit [31:0] outs,
                         input bit [31:0] st);
    check({tag, ".busy"}, busy_mask, busy);
    check({tag, ".outstanding"}, 32'(outstanding), outs);
    check({tag, ".state"}, 32'(state_o), st);
  endtask

  initial begin
    issue_ready = 1'b1;
    wb_vld = 1'b0; wb_rd = 5'd0; sys_done = 1'b0; flush = 1'b0;
    wr_inst(1);
    @(posedge clk);
    #1;
    tick("reset", 0, 0);
    chk_reg("reset", 32'h0, 0, 0);
    rst = 1'b0;
    idle();

    // back-to-back RAW, bypassed writeback
    set_dec(1, 5, 1, 1, 0, 0, 1, 0); tick("raw_a", 1, 1); chk_reg("raw_a", 32'h20, 1, 0);
    set_dec(1, 6, 5, 1, 1, 1, 1, 0); tick("raw_b", 0, 0); chk_reg("raw_b", 32'h20, 1, 0);
    wb(5);                           tick("raw_c", 1, 1); chk_reg("raw_c", 32'h40, 1, 0);
    idle(); wb(6);                   tick("raw_wb", 0, 1); chk_reg("raw_wb", 32'h0, 0, 0);

    // x0 writes never occupy the scoreboard
    wr_inst(0); tick("x0_a", 1, 1);
    tick("x0_b", 1, 1); chk_reg("x0", 32'h0, 0, 0);

    // WAW on x7; same-cycle writeback and re-set keeps the bit
    wr_inst(7); tick("waw_a", 1, 1); chk_reg("waw_a", 32'h80, 1, 0);
    tick("waw_b", 0, 0); chk_reg("waw_b", 32'h80, 1, 0);
    wb(7); tick("waw_c", 1, 1); chk_reg("waw_c", 32'h80, 1, 0);
    idle(); wb(7); tick("waw_wb", 0, 1); chk_reg("waw_wb", 32'h0, 0, 0);

    // outstanding limit
    for (int i = 1; i <= 4; i++) begin
      wr_inst(i);
      tick("lim_fill", 1, 1);
    end
    chk_reg("lim_full", 32'h1E, 4, 0);
    wr_inst(8); tick("lim_stall", 0, 0); chk_reg("lim_stall", 32'h1E, 4, 0);
    wb(2);      tick("lim_swap", 1, 1);  chk_reg("lim_swap", 32'h11A, 4, 0);
    idle(); wb(9); tick("wb_stale", 0, 1); chk_reg("wb_stale", 32'h11A, 4, 0);
    wb(1); tick("lim_d1", 0, 1);
    wb(3); tick("lim_d3", 0, 1);
    wb(4); tick("lim_d4", 0, 1);
    wb(8); tick("lim_d8", 0, 1);
    chk_reg("lim_empty", 32'h0, 0, 0);

    // serialise an ecall behind two writers
    wr_inst(10); tick("ser_w10", 1, 1);
    wr_inst(11); tick("ser_w11", 1, 1); chk_reg("ser_pre", 32'hC00, 2, 0);
    ecall();     tick("ser_a", 0, 0);     chk_reg("ser_a", 32'hC00, 2, 1);
    wb(10);      tick("ser_wb10", 0, 0);  chk_reg("ser_wb10", 32'h800, 1, 1);
    wb(11);      tick("ser_wb11", 0, 0);  chk_reg("ser_wb11", 32'h0, 0, 1);
    tick("ser_issue", 1, 1);              chk_reg("ser_issue", 32'h0, 0, 2);
    wr_inst(12); tick("ser_hold", 0, 0);  chk_reg("ser_hold", 32'h0, 0, 2);
    sys_done = 1'b1; tick("ser_done", 0, 0); chk_reg("ser_done", 32'h0, 0, 0);
    tick("ser_after", 1, 1);              chk_reg("ser_after", 32'h1000, 1, 0);

    // csr writing x13 enters SERIAL with a busy bit, then flush
    set_dec(1, 13, 0, 0, 0, 0, 1, 1); tick("csr_a", 0, 0); chk_reg("csr_a", 32'h1000, 1, 1);
    wb(12);                           tick("csr_wb", 0, 0); chk_reg("csr_wb", 32'h0, 0, 1);
    tick("csr_issue", 1, 1);          chk_reg("csr_issue", 32'h2000, 1, 2);
    wr_inst(14); flush = 1'b1; tick("flush", 0, 0); chk_reg("flush", 32'h2000, 1, 0);
    idle(); sys_done = 1'b1;   tick("sd_ignored", 0, 1); chk_reg("sd_ignored", 32'h2000, 1, 0);
    wr_inst(14);               tick("post_flush", 1, 1); chk_reg("post_flush", 32'h6000, 2, 0);

    // execute back-pressure
    issue_ready = 1'b0;
    set_dec(1, 15, 1, 1, 0, 0, 1, 0); tick("bp_hold", 1, 0); chk_reg("bp_hold", 32'h6000, 2, 0);
    issue_ready = 1'b1;               tick("bp_go", 1, 1);   chk_reg("bp_go", 32'hE000, 3, 0);

    // asynchronous reset while draining
    ecall(); tick("drain", 0, 0); chk_reg("drain", 32'hE000, 3, 1);
    #1 rst = 1'b1;
    #1;
    chk_reg("async_rst", 32'h0, 0, 0);
    check("async_rst.issue_vld", 32'(issue_vld), 0);
    check("async_rst.dec_ready", 32'(dec_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(); wb(13); tick("post_rst_wb", 0, 1); chk_reg("post_rst_wb", 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
